regfile_wb_arb: RTL and testbench
=================================

# regfile_wb_arb

Write-back arbiter for the 32-entry general-purpose register file. It shares the register file's single write port between two sources. The ALU write-back path cannot stall and gets priority. The load/multicycle (mem) write-back path uses a valid/ready handshake and a small in-order buffer. The block sits between the pipeline's write-back stage and the register file's `wren`/`addr_w`/`data_w` inputs, and gives decode a per-register pending-write scoreboard.

## Interface
- `DATA_W`, 32, register width
- `ADDR_W`, 5, register address width
- `DEPTH`, 2, mem-path buffer entries (≥1)
- `STARVE_MAX`, 4, cycles a buffered head may wait before forced service (≥1)

Ports:
- `clk` in 1: the single clock.
- `aclr` in 1: reset, synchronous and active-high.
- `alu_valid` in 1: ALU write request.
- `alu_addr` in ADDR_W, `alu_data` in DATA_W: ALU write target and data.
- `alu_stall` out 1: ALU request not accepted this cycle; upstream holds it.
- `mem_valid` in 1, `mem_ready` out 1: mem-path handshake.
- `mem_addr` in ADDR_W, `mem_data` in DATA_W: mem write target and data.
- `rf_wren` out 1, `rf_addr_w` out ADDR_W, `rf_data_w` out DATA_W: to the register file write port.
- `chk_addr_a` in ADDR_W, `chk_addr_b` in ADDR_W: decode source registers.
- `chk_busy_a` out 1, `chk_busy_b` out 1: the corresponding register has a pending write.
- `pend_count` out clog2(DEPTH+1): buffer occupancy.

## Operation
- Mem transfer: accepted when `mem_valid && mem_ready`. Addr 0 is accepted and dropped, not enqueued. Otherwise the entry {addr, data, live=1} is pushed to the FIFO tail.
- Grant per cycle, in priority order:
  1. `alu_stall`=1: pop the FIFO head. The ALU is not accepted.
  2. `alu_valid`: accept the ALU request.
  3. FIFO non-empty: pop the head.
  4. Otherwise idle.
- ALU accept with addr 0 consumes the grant but produces no write.
- Squash (WAW ordering): an accepted ALU write with addr≠0 clears `live` on every FIFO entry with the same addr. This includes an entry enqueued in the same cycle, because a same-cycle mem transfer is treated as older.
- A popped entry with live=0 produces `rf_wren`=0.
- Starvation counter: increments each cycle the head is valid and not popped. It clears on pop or when the FIFO is empty. `alu_stall` is registered and asserts the cycle after the counter reaches STARVE_MAX. It deasserts the cycle after the forced pop.
- Scoreboard: `chk_busy_x`=1 iff `chk_addr_x`≠0 and it matches either a live FIFO entry's addr or the output register while `rf_wren`=1. This is combinational from state.

## Timing
- All outputs are registered, except `chk_busy_*` and `pend_count`, which are decoded from registers.
- Latency: grant in cycle N → `rf_wren`/`rf_addr_w`/`rf_data_w` valid in cycle N+1 → register file written at the end of N+1.
- `mem_ready` in cycle N+1 = (occupancy after cycle N's push/pop) < DEPTH.
  - When full, `mem_ready`=0 even in a popping cycle; it rises the following cycle.
- Simultaneous push and pop: occupancy unchanged. FIFO pointers wrap modulo DEPTH.
- Reset values (cycle after `aclr` sampled high): `rf_wren`=0, `rf_addr_w`=0, `rf_data_w`=0, `alu_stall`=0, `mem_ready`=0, `pend_count`=0, FIFO empty, counter=0.
  - `mem_ready` rises the first cycle after `aclr` deasserts.
- Reset mid-operation: buffered writes are discarded without being written.

## Configuration
- `WB_STARVE_GUARD_EN` defined: starvation counter and forced service as above.
- Not defined: no counter, `alu_stall` tied 0, ALU always wins, and `STARVE_MAX` is ignored.

## Test plan
- Reset then idle: `aclr`=1 for 2 cycles → all outputs 0; `mem_ready`=1 one cycle after release.
- ALU only: `alu_valid`, addr 1, data 0xF0F0F0F0 in cycle N → `rf_wren`=1, addr 1, data 0xF0F0F0F0 in N+1; register 1 reads 0xF0F0F0F0 in N+2. Addr 0 request → `rf_wren` stays 0.
- Contention: mem writes r3=0x11, r4=0x22 while `alu_valid` is held on r5.
  - Guard off → mem writes are not serviced while `alu_valid` stays high.
  - Guard on (STARVE_MAX=4) → `alu_stall`=1 exactly once per STARVE_MAX+1 cycles; r3 is written before r4.
- Full buffer (DEPTH=2, ALU busy): after 2 mem pushes → `mem_ready`=0 and `pend_count`=2; a third `mem_valid` is held off until a pop.
- Squash: mem r7=0xAA buffered, then ALU r7=0xBB accepted → only 0xBB reaches r7; the popped entry gives `rf_wren`=0.
- Scoreboard and reset: r9 buffered → `chk_busy_a` with `chk_addr_a`=9 is 1 and with `chk_addr_a`=0 is 0. `aclr` pulsed with 2 entries pending → `pend_count`=0, no writes issued.

Source files
------------

// File: rtl/regfile_wb_arb_if.sv
// Write-back arbiter bus bundle.
// Groups every handshake and data signal between the pipeline write-back
// stage, decode, the register file write port and the arbiter.
//   master : pipeline side (drives ALU/mem requests and decode check addresses)
//   slave  : arbiter side (drives stall, mem_ready, register file write port,
//            scoreboard busy flags and buffer occupancy)
interface regfile_wb_arb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_stall;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    logic              rf_wren;
    logic [ADDR_W-1:0] rf_addr_w;
    logic [DATA_W-1:0] rf_data_w;

    logic [ADDR_W-1:0] chk_addr_a;
    logic [ADDR_W-1:0] chk_addr_b;
    logic              chk_busy_a;
    logic              chk_busy_b;

    logic [$clog2(DEPTH+1)-1:0] pend_count;

    modport master (
        output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
               chk_addr_a, chk_addr_b,
        input  alu_stall, mem_ready, rf_wren, rf_addr_w, rf_data_w,
               chk_busy_a, chk_busy_b, pend_count
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
               chk_addr_a, chk_addr_b,
        output alu_stall, mem_ready, rf_wren, rf_addr_w, rf_data_w,
               chk_busy_a, chk_busy_b, pend_count
    );
endinterface

// File: rtl/regfile_wb_arb.sv
// Register file write-back arbiter.
// Shares the single register file write port between the non-stallable ALU
// path (priority) and the mem path (valid/ready into a small in-order FIFO).
// An ALU write squashes older buffered writes to the same register so the
// architectural result obeys WAW order. A per-register pending-write
// scoreboard is offered to decode.
// Ports:
//   clk  : clock
//   aclr : synchronous active-high reset
//   bus  : regfile_wb_arb_if.slave (ALU/mem requests, rf write port,
//          scoreboard check/busy, pend_count)
// Optional feature macro: WB_STARVE_GUARD_EN enables the starvation counter
// and forced FIFO service via alu_stall; without it alu_stall is 0.
module regfile_wb_arb #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             aclr,
    regfile_wb_arb_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

    // Elaboration-time parameter sanity.
    if (DEPTH < 1 || STARVE_MAX < 1) begin : g_bad_param
        $fatal(1, "regfile_wb_arb: DEPTH and STARVE_MAX must be >= 1");
    end

    logic [ADDR_W-1:0] fifo_addr_r [DEPTH];
    logic [DATA_W-1:0] fifo_data_r [DEPTH];
    logic [DEPTH-1:0]  fifo_live_r;
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  count_r, count_next_s;
    logic              mem_ready_r;
    logic              rf_wren_r;
    logic [ADDR_W-1:0] rf_addr_w_r;
    logic [DATA_W-1:0] rf_data_w_r;

    logic head_valid_s, push_s, pop_s, alu_acc_s, squash_s, alu_stall_s;
    logic hit_a_s, hit_b_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign head_valid_s = (count_r != '0);
    // Address 0 transfers complete the handshake but never enter the FIFO.
    assign push_s   = bus.mem_valid && mem_ready_r && (bus.mem_addr != '0);
    assign squash_s = alu_acc_s && (bus.alu_addr != '0);

    // Grant: forced FIFO service, then ALU, then FIFO, then idle.
    always_comb begin
        alu_acc_s = 1'b0;
        pop_s     = 1'b0;
        if (alu_stall_s) begin
            pop_s = head_valid_s;
        end else if (bus.alu_valid) begin
            alu_acc_s = 1'b1;
        end else if (head_valid_s) begin
            pop_s = 1'b1;
        end else begin
            alu_acc_s = 1'b0;
            pop_s     = 1'b0;
        end
    end

    // Occupancy after this cycle's push/pop.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage, pointers, occupancy and registered mem_ready.
    always_ff @(posedge clk) begin
        if (aclr) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr_r[i] <= '0;
                fifo_data_r[i] <= '0;
            end
            fifo_live_r <= '0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            mem_ready_r <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash_s && (fifo_addr_r[i] == bus.alu_addr)) begin
                    fifo_live_r[i] <= 1'b0;
                end
            end
            // live doubles as entry-valid, so a popped slot is cleared.
            if (pop_s) begin
                fifo_live_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r              <= ptr_inc(rd_ptr_r);
            end
            // Same-cycle mem push counts as older than the ALU write.
            if (push_s) begin
                fifo_addr_r[wr_ptr_r] <= bus.mem_addr;
                fifo_data_r[wr_ptr_r] <= bus.mem_data;
                fifo_live_r[wr_ptr_r] <= !(squash_s && (bus.mem_addr == bus.alu_addr));
                wr_ptr_r              <= ptr_inc(wr_ptr_r);
            end
            count_r     <= count_next_s;
            mem_ready_r <= (count_next_s < DEPTH_C);
        end
    end

    // Register file write port output register.
    always_ff @(posedge clk) begin
        if (aclr) begin
            rf_wren_r   <= 1'b0;
            rf_addr_w_r <= '0;
            rf_data_w_r <= '0;
        end else if (alu_acc_s) begin
            rf_wren_r   <= (bus.alu_addr != '0);
            rf_addr_w_r <= bus.alu_addr;
            rf_data_w_r <= bus.alu_data;
        end else if (pop_s) begin
            rf_wren_r   <= fifo_live_r[rd_ptr_r];
            rf_addr_w_r <= fifo_addr_r[rd_ptr_r];
            rf_data_w_r <= fifo_data_r[rd_ptr_r];
        end else begin
            rf_wren_r   <= 1'b0;
        end
    end

`ifdef WB_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] SMAX_C = SC_W'(STARVE_MAX);

    logic [SC_W-1:0] starve_r, starve_next_s;
    logic            stall_r;

    // Head wait counter; saturates, cleared by a pop or an empty FIFO.
    always_comb begin
        if (pop_s || !head_valid_s) begin
            starve_next_s = '0;
        end else if (starve_r == SMAX_C) begin
            starve_next_s = starve_r;
        end else begin
            starve_next_s = starve_r + SC_W'(1);
        end
    end

    // Counter and registered forced-service request.
    always_ff @(posedge clk) begin
        if (aclr) begin
            starve_r <= '0;
            stall_r  <= 1'b0;
        end else begin
            starve_r <= starve_next_s;
            stall_r  <= (starve_next_s == SMAX_C);
        end
    end

    assign alu_stall_s = stall_r;
`else
    assign alu_stall_s = 1'b0;
`endif

    // Scoreboard hit search over live FIFO entries.
    always_comb begin
        hit_a_s = 1'b0;
        hit_b_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_a_s = hit_a_s | (fifo_live_r[i] && (fifo_addr_r[i] == bus.chk_addr_a));
            hit_b_s = hit_b_s | (fifo_live_r[i] && (fifo_addr_r[i] == bus.chk_addr_b));
        end
    end

    assign bus.chk_busy_a = (bus.chk_addr_a != '0) &&
                            (hit_a_s || (rf_wren_r && (rf_addr_w_r == bus.chk_addr_a)));
    assign bus.chk_busy_b = (bus.chk_addr_b != '0) &&
                            (hit_b_s || (rf_wren_r && (rf_addr_w_r == bus.chk_addr_b)));

    assign bus.alu_stall  = alu_stall_s;
    assign bus.mem_ready  = mem_ready_r;
    assign bus.rf_wren    = rf_wren_r;
    assign bus.rf_addr_w  = rf_addr_w_r;
    assign bus.rf_data_w  = rf_data_w_r;
    assign bus.pend_count = count_r;
endmodule

// File: tb/tb_regfile_wb_arb.sv
// Self-checking bench for regfile_wb_arb: directed vector table plus
// hand-written sequences for reset, scoreboard, contention and mid-run reset.
module tb_regfile_wb_arb;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;
    localparam int NVEC   = 18;

    logic clk;
    logic aclr;

    regfile_wb_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    regfile_wb_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_MAX(4)) dut (
        .clk  (clk),
        .aclr (aclr),
        .bus  (bus.slave)
    );

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        ew;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        er;
        logic [1:0]  ep;
    } vec_t;

    vec_t        vecs [NVEC];
    logic [31:0] rf_model [32];
    int          pass_cnt = 0;
    int          total_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side register file driven by the write port.
    always @(posedge clk) begin
        if (bus.rf_wren === 1'b1) rf_model[bus.rf_addr_w] <= bus.rf_data_w;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic mv, input logic [4:0] ma, input logic [31:0] md,
                                input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                                input logic er, input logic [1:0] ep);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad;
        v.mv = mv; v.ma = ma; v.md = md;
        v.ew = ew; v.ea = ea; v.ed = ed;
        v.er = er; v.ep = ep;
        return v;
    endfunction

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
        bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
    endtask

    initial begin
        int stalls, first_stall, second_stall, r3_cyc, r4_cyc, stray;
        int exp_stalls, exp_first, exp_second, exp_r3, exp_r4;

        //           av aa     ad            mv ma     md          ew ea     ed            er    ep
        vecs[0]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      0, 5'd0,  32'h0,        1'b1, 2'd0);
        vecs[1]  = mk(1, 5'd1,  32'hF0F0F0F0, 0, 5'd0,  32'h0,      1, 5'd1,  32'hF0F0F0F0, 1'b1, 2'd0);
        vecs[2]  = mk(1, 5'd0,  32'h1234,     0, 5'd0,  32'h0,      0, 5'd0,  32'h0,        1'b1, 2'd0);
        vecs[3]  = mk(0, 5'd0,  32'h0,        1, 5'd2,  32'h55,     0, 5'd0,  32'h0,        1'b1, 2'd1);
        vecs[4]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      1, 5'd2,  32'h55,       1'b1, 2'd0);
        vecs[5]  = mk(1, 5'd5,  32'h5,        1, 5'd3,  32'h11,     1, 5'd5,  32'h5,        1'b1, 2'd1);
        vecs[6]  = mk(1, 5'd5,  32'h6,        1, 5'd4,  32'h22,     1, 5'd5,  32'h6,        1'b0, 2'd2);
        vecs[7]  = mk(1, 5'd6,  32'h7,        1, 5'd8,  32'h33,     1, 5'd6,  32'h7,        1'b0, 2'd2);
        vecs[8]  = mk(0, 5'd0,  32'h0,        1, 5'd8,  32'h33,     1, 5'd3,  32'h11,       1'b1, 2'd1);
        vecs[9]  = mk(0, 5'd0,  32'h0,        1, 5'd8,  32'h33,     1, 5'd4,  32'h22,       1'b1, 2'd1);
        vecs[10] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      1, 5'd8,  32'h33,       1'b1, 2'd0);
        vecs[11] = mk(0, 5'd0,  32'h0,        1, 5'd0,  32'h99,     0, 5'd0,  32'h0,        1'b1, 2'd0);
        vecs[12] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      0, 5'd0,  32'h0,        1'b1, 2'd0);
        vecs[13] = mk(0, 5'd0,  32'h0,        1, 5'd7,  32'hAA,     0, 5'd0,  32'h0,        1'b1, 2'd1);
        vecs[14] = mk(1, 5'd7,  32'hBB,       0, 5'd0,  32'h0,      1, 5'd7,  32'hBB,       1'b1, 2'd1);
        vecs[15] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      0, 5'd0,  32'h0,        1'b1, 2'd0);
        vecs[16] = mk(1, 5'd10, 32'hCC,       1, 5'd10, 32'hDD,     1, 5'd10, 32'hCC,       1'b1, 2'd1);
        vecs[17] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      0, 5'd0,  32'h0,        1'b1, 2'd0);

        // Reset then idle.
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        bus.chk_addr_a = 5'd0;
        bus.chk_addr_b = 5'd0;
        aclr = 1'b1;
        step();
        step();
        check("rst rf_wren",    {31'd0, bus.rf_wren},    32'd0);
        check("rst rf_addr_w",  {27'd0, bus.rf_addr_w},  32'd0);
        check("rst rf_data_w",  bus.rf_data_w,           32'd0);
        check("rst alu_stall",  {31'd0, bus.alu_stall},  32'd0);
        check("rst mem_ready",  {31'd0, bus.mem_ready},  32'd0);
        check("rst pend_count", {30'd0, bus.pend_count}, 32'd0);
        aclr = 1'b0;
        step();
        check("release mem_ready", {31'd0, bus.mem_ready}, 32'd1);

        // Directed vector table.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].mv, vecs[i].ma, vecs[i].md);
            step();
            check($sformatf("v%0d rf_wren", i), {31'd0, bus.rf_wren}, {31'd0, vecs[i].ew});
            if (vecs[i].ew) begin
                check($sformatf("v%0d rf_addr_w", i), {27'd0, bus.rf_addr_w}, {27'd0, vecs[i].ea});
                check($sformatf("v%0d rf_data_w", i), bus.rf_data_w, vecs[i].ed);
            end
            check($sformatf("v%0d mem_ready", i),  {31'd0, bus.mem_ready},  {31'd0, vecs[i].er});
            check($sformatf("v%0d pend_count", i), {30'd0, bus.pend_count}, {30'd0, vecs[i].ep});
        end
        check("rf r1", rf_model[1], 32'hF0F0F0F0);
        check("rf r2", rf_model[2], 32'h55);
        check("rf r7 squash", rf_model[7], 32'hBB);
        check("rf r10 same-cycle squash", rf_model[10], 32'hCC);

        // Scoreboard.
        drive(1, 5'd5, 32'h50, 1, 5'd9, 32'h9);
        step();
        drive(1, 5'd5, 32'h50, 0, 5'd0, 32'h0);
        bus.chk_addr_a = 5'd9;
        bus.chk_addr_b = 5'd0;
        #1;
        check("busy r9 buffered", {31'd0, bus.chk_busy_a}, 32'd1);
        check("busy r0",          {31'd0, bus.chk_busy_b}, 32'd0);
        bus.chk_addr_a = 5'd0;
        bus.chk_addr_b = 5'd5;
        #1;
        check("busy a r0",        {31'd0, bus.chk_busy_a}, 32'd0);
        check("busy r5 out reg",  {31'd0, bus.chk_busy_b}, 32'd1);
        step();
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        step();
        bus.chk_addr_a = 5'd9;
        #1;
        check("busy r9 out reg",  {31'd0, bus.chk_busy_a}, 32'd1);
        step();
        #1;
        check("busy r9 retired",  {31'd0, bus.chk_busy_a}, 32'd0);
        bus.chk_addr_a = 5'd0;
        bus.chk_addr_b = 5'd0;

        // Contention: ALU held on r5 for cycles 0..14 while mem pushes r3, r4.
        stalls = 0; first_stall = -1; second_stall = -1; r3_cyc = -1; r4_cyc = -1;
        for (int c = 0; c < 18; c++) begin
            drive(c < 15, 5'd5, 32'h5, c < 2, (c == 0) ? 5'd3 : 5'd4, (c == 0) ? 32'h11 : 32'h22);
            #1;
            if (bus.alu_stall === 1'b1) begin
                stalls++;
                if (first_stall < 0) first_stall = c;
                else if (second_stall < 0) second_stall = c;
            end
            if (bus.rf_wren === 1'b1 && bus.rf_addr_w == 5'd3 && r3_cyc < 0) r3_cyc = c;
            if (bus.rf_wren === 1'b1 && bus.rf_addr_w == 5'd4 && r4_cyc < 0) r4_cyc = c;
            if (c == 14) begin
`ifdef WB_STARVE_GUARD_EN
                check("contention pend_count", {30'd0, bus.pend_count}, 32'd0);
`else
                check("contention pend_count", {30'd0, bus.pend_count}, 32'd2);
`endif
            end
            step();
        end
`ifdef WB_STARVE_GUARD_EN
        exp_stalls = 2; exp_first = 5; exp_second = 10; exp_r3 = 6; exp_r4 = 11;
`else
        exp_stalls = 0; exp_first = -1; exp_second = -1; exp_r3 = 16; exp_r4 = 17;
`endif
        check("stall count",  stalls,       exp_stalls);
        check("first stall",  first_stall,  exp_first);
        check("second stall", second_stall, exp_second);
        check("r3 write cyc", r3_cyc,       exp_r3);
        check("r4 write cyc", r4_cyc,       exp_r4);
        check("rf r3", rf_model[3], 32'h11);
        check("rf r4", rf_model[4], 32'h22);

        // Reset with two entries pending.
        drive(1, 5'd5, 32'h5, 1, 5'd11, 32'h1);
        step();
        drive(1, 5'd5, 32'h5, 1, 5'd12, 32'h2);
        step();
        check("pre-reset pend_count", {30'd0, bus.pend_count}, 32'd2);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        aclr = 1'b1;
        step();
        check("mid-reset pend_count", {30'd0, bus.pend_count}, 32'd0);
        check("mid-reset rf_wren",    {31'd0, bus.rf_wren},    32'd0);
        aclr = 1'b0;
        stray = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (bus.rf_wren !== 1'b0) stray++;
        end
        check("no writes after reset", stray, 32'd0);
        check("post-reset mem_ready", {31'd0, bus.mem_ready}, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
